// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and register-number constants.
package hazard_unit_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-source forwarding matcher: EXE > MEM > WB priority, plus per-stage load-hit flags.
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int unsigned AW = REG_AW
) (
  input  logic [AW-1:0] src_i,
  input  logic          src_used_i,
  input  logic          exe_wen_i,
  input  logic [AW-1:0] exe_wnum_i,
  input  logic          mem_wen_i,
  input  logic [AW-1:0] mem_wnum_i,
  input  logic          wb_wen_i,
  input  logic [AW-1:0] wb_wnum_i,
  input  logic          exe_is_load_i,
  input  logic          mem_is_load_i,
  output logic [1:0]    sel_o,
  output logic          exe_load_hit_o,
  output logic          mem_load_hit_o
);

  logic src_live;
  logic exe_hit, mem_hit, wb_hit;

  // A source of r0 never matches, so checking the source covers wnum != 0 as well.
  assign src_live = src_used_i && (src_i != AW'(REG_ZERO));

  assign exe_hit = src_live && exe_wen_i && (exe_wnum_i == src_i);
  assign mem_hit = src_live && mem_wen_i && (mem_wnum_i == src_i);
  assign wb_hit  = src_live && wb_wen_i  && (wb_wnum_i  == src_i);

  assign exe_load_hit_o = exe_hit && exe_is_load_i;
  assign mem_load_hit_o = mem_hit && mem_is_load_i;

  always_comb begin
    sel_o = FWD_RF;
    if (exe_hit)      sel_o = FWD_EXE;
    else if (mem_hit) sel_o = FWD_MEM;
    else if (wb_hit)  sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: operand forwarding, load-use and MDU interlocks, branch flush, stall counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned AW       = REG_AW,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic                  id_mdu_op,
  input  logic                  id_reads_hilo,
  input  logic                  exe_wen,
  input  logic                  mem_wen,
  input  logic                  wb_wen,
  input  logic [AW-1:0]         exe_wnum,
  input  logic [AW-1:0]         mem_wnum,
  input  logic [AW-1:0]         wb_wnum,
  input  logic                  exe_is_load,
  input  logic                  mem_is_load,
  input  logic                  ex_branch_taken,
  output logic [2*NUM_SRC-1:0]  fwd_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  mdu_start,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned CW     = $clog2(MDU_LAT + 1);
  localparam logic        LU_MEM = (LOAD_LAT > 1);

  logic [NUM_SRC-1:0] exe_ld_hit;
  logic [NUM_SRC-1:0] mem_ld_hit;
  logic               lu_stall;
  logic               mdu_stall;
  logic               stall;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_fwd_sel #(
      .AW(AW)
    ) u_fwd (
      .src_i         (id_src[i*AW +: AW]),
      .src_used_i    (id_src_used[i]),
      .exe_wen_i     (exe_wen),
      .exe_wnum_i    (exe_wnum),
      .mem_wen_i     (mem_wen),
      .mem_wnum_i    (mem_wnum),
      .wb_wen_i      (wb_wen),
      .wb_wnum_i     (wb_wnum),
      .exe_is_load_i (exe_is_load),
      .mem_is_load_i (mem_is_load),
      .sel_o         (fwd_sel[2*i +: 2]),
      .exe_load_hit_o(exe_ld_hit[i]),
      .mem_load_hit_o(mem_ld_hit[i])
    );
  end

  assign lu_stall  = id_valid && ((|exe_ld_hit) || (LU_MEM && (|mem_ld_hit)));
  assign mdu_busy  = (cnt_q != '0);
  assign mdu_stall = id_valid && mdu_busy && (id_mdu_op || id_reads_hilo);
  // rst_n gating keeps the launch pulse quiet while reset is held.
  assign mdu_start = rst_n && id_valid && id_mdu_op && !mdu_busy && !lu_stall && !ex_branch_taken;

  assign stall     = (lu_stall || mdu_stall) && !ex_branch_taken;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;
  assign flush_id  = ex_branch_taken;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (mdu_start)     cnt_d = CW'(MDU_LAT);
    else if (mdu_busy) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding detector: computes per-source forwarding selects with strict EXE > MEM > WB priority for NUM_SRC decode-stage read ports.
- Adds load-use stall detection, a multi-cycle MDU (mul/div) busy tracker with interlock, and branch-flush control.
- Adds a saturating stall-cycle counter for performance monitoring.
- Sits beside the ID stage; its outputs drive the ID operand muxes and the IF/ID/EX pipeline-register enables.

Parameters:
- AW, 5, register-number width.
- NUM_SRC, 2, number of ID source operands checked.
- LOAD_LAT, 1, load-use stall depth; 1 or 2. With 2, a load in MEM also causes a stall.
- MDU_LAT, 32, MDU busy cycles per operation; must be >= 2.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*AW  source register numbers; source i occupies bits [i*AW +: AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- id_mdu_op  in  1  ID instruction starts an MDU operation.
- id_reads_hilo  in  1  ID instruction reads the MDU result (mfhi/mflo).
- exe_wen, mem_wen, wb_wen  in  1 each  stage register write enable.
- exe_wnum, mem_wnum, wb_wnum  in  AW each  stage destination register.
- exe_is_load, mem_is_load  in  1 each  stage holds a load.
- ex_branch_taken  in  1  branch resolved taken in EX.
- fwd_sel  out  2*NUM_SRC  per source: 00 = regfile, 01 = EXE, 10 = MEM, 11 = WB.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_id  out  1  squash the IF/ID instruction.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_busy  out  1  MDU operation in flight.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Forwarding (combinational):
  - A stage matches source i when: its wen = 1, its wnum == id_src[i], its wnum != 0, and id_src_used[i] = 1.
  - Select value is the first matching stage in the order EXE, MEM, WB; otherwise 00.
  - WB encodes 11 for every source, including rt-position sources.
- Load-use stall (combinational): lu_stall = id_valid & any source matching an EXE load. When LOAD_LAT = 2, a source matching a MEM load also asserts lu_stall.
- MDU interlock:
  - Internal counter cnt, width clog2(MDU_LAT+1).
  - mdu_busy = (cnt != 0).
  - mdu_stall = id_valid & mdu_busy & (id_mdu_op | id_reads_hilo).
  - mdu_start = id_valid & id_mdu_op & ~mdu_busy & ~lu_stall & ~ex_branch_taken.
  - On mdu_start, cnt loads MDU_LAT. Otherwise, when cnt != 0, cnt decrements by 1 per cycle.
  - An op issued in the cycle cnt goes 1 -> 0 still stalls; it issues the following cycle.
- Stall outputs:
  - stall = (lu_stall | mdu_stall) & ~ex_branch_taken.
  - stall_if = stall_id = bubble_ex = stall.
- Flush: flush_id = ex_branch_taken. Flush overrides any stall, because the stalled instruction is the one discarded.
- Stall counter: stall_cnt increments by 1 each cycle stall = 1 and saturates at all-ones; it does not wrap.
- Reset: rst_n low asynchronously clears cnt and stall_cnt.
  - While reset is held, mdu_busy = 0 and mdu_start = 0.
  - Combinational outputs follow their inputs.
  - Reset asserted mid-MDU-operation abandons the operation; after release, mdu_busy = 0 immediately.
- Latency: forwarding and stall/flush are zero-cycle. mdu_busy rises the cycle after mdu_start and stays high for exactly MDU_LAT cycles.

Decomposition:
- Shared package:
  - FWD_RF/FWD_EXE/FWD_MEM/FWD_WB 2-bit encodings.
  - Register-number width constant.
  - Constant for register 0.
- One sub-module, hazard_fwd_sel: a single-source priority matcher, instantiated NUM_SRC times in a generate loop.
- The MDU counter and the stall counter remain in the top module.

Test Plan:
- Priority: id_src = {rt=5, rs=5}, exe/mem/wb all write r5 -> fwd_sel = 01 for both sources. Clear exe_wen -> 10. Clear mem_wen -> 11.
- r0 and unused sources:
  - id_src rs = 0 with exe writing r0 -> fwd_sel = 00.
  - rs = 7 with id_src_used = 0 and exe writing r7 -> 00, and no stall.
- Load-use (LOAD_LAT = 1): exe_is_load, exe_wnum = 3, id rs = 3 -> stall_if/stall_id/bubble_ex = 1 for one cycle. Next cycle, with the load moved to MEM -> stall 0, fwd_sel = 10. Repeat with LOAD_LAT = 2 -> stall for 2 cycles.
- MDU (MDU_LAT = 4): id_mdu_op -> mdu_start pulses once; mdu_busy high for 4 cycles. A following id_reads_hilo stalls until busy drops, then proceeds; stall_cnt increases by the number of stalled cycles.
- Branch: ex_branch_taken together with a load-use match -> flush_id = 1, stall = 0, mdu_start = 0, stall_cnt unchanged.
- Reset/saturation:
  - rst_n pulsed low during busy -> mdu_busy = 0 and stall_cnt = 0 after release.
  - With CNT_W = 3, stalling for 10 cycles -> stall_cnt holds at 7.
